// File: rtl/add_round_key_pkg.sv
// add_round_key_pkg: shared AES widths, types and index helper for the AddRoundKey stage
package add_round_key_pkg;
  localparam int AES_BLOCK_W = 128;
  localparam int AES128_NUM_KEYS = 11;
  localparam int ROUND_IDX_W = $clog2(AES128_NUM_KEYS);
  typedef logic [AES_BLOCK_W-1:0] aes_block_t;
  typedef logic [ROUND_IDX_W-1:0] round_idx_t;
  function automatic logic idx_ok(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction
endpackage

// File: rtl/add_round_key_if.sv
// add_round_key_if: key-load port plus valid/ready state-in and result-out channels
interface add_round_key_if #(
  parameter int WIDTH = 128,
  parameter int IDX_W = 4
) ();
  logic             key_wr_en;
  logic [IDX_W-1:0] key_wr_idx;
  logic [WIDTH-1:0] key_wr_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_state;
  logic [IDX_W-1:0] in_round;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_state;
  logic [IDX_W-1:0] out_round;
  logic             out_err;
  modport master (
    output key_wr_en, key_wr_idx, key_wr_data, in_valid, in_state, in_round, out_ready,
    input  in_ready, out_valid, out_state, out_round, out_err
  );
  modport slave (
    input  key_wr_en, key_wr_idx, key_wr_data, in_valid, in_state, in_round, out_ready,
    output in_ready, out_valid, out_state, out_round, out_err
  );
endinterface

// File: rtl/add_round_key_round_key_bank.sv
// round_key_bank: round-key registers with sync write, async read; out-of-range reads return 0
module round_key_bank
  import add_round_key_pkg::*;
#(
  parameter int WIDTH = AES_BLOCK_W,
  parameter int NUM_KEYS = AES128_NUM_KEYS,
  parameter int IDX_W = $clog2(NUM_KEYS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_key,
  output logic             rd_err
);
  logic [WIDTH-1:0] keys [NUM_KEYS];
  logic             wr_ok;
  assign wr_ok  = idx_ok(32'(wr_idx), NUM_KEYS);
  assign rd_err = !idx_ok(32'(rd_idx), NUM_KEYS);
  // read is combinational off the pre-edge contents, so a same-edge write is seen next access
  assign rd_key = rd_err ? '0 : keys[rd_idx];
  always_ff @(posedge clk) begin
    if (!rst_n) keys <= '{default: '0};
    else if (wr_en && wr_ok) keys[wr_idx] <= wr_data;
  end
endmodule

// File: rtl/add_round_key.sv
// add_round_key: XORs the state with the selected round key into a one-deep valid/ready output register
module add_round_key
  import add_round_key_pkg::*;
#(
  parameter int WIDTH = AES_BLOCK_W,
  parameter int NUM_KEYS = AES128_NUM_KEYS,
  parameter int IDX_W = $clog2(NUM_KEYS)
) (
  input logic            clk,
  input logic            rst_n,
  add_round_key_if.slave bus
);
  logic [WIDTH-1:0] key;
  logic             key_err;
  logic             accept;
  logic             valid_q;
  logic [WIDTH-1:0] state_q;
  logic [IDX_W-1:0] round_q;
  logic             err_q;
  round_key_bank #(.WIDTH(WIDTH), .NUM_KEYS(NUM_KEYS), .IDX_W(IDX_W)) u_bank (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (bus.key_wr_en),
    .wr_idx (bus.key_wr_idx),
    .wr_data(bus.key_wr_data),
    .rd_idx (bus.in_round),
    .rd_key (key),
    .rd_err (key_err)
  );
  assign bus.in_ready  = !valid_q || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_state = state_q;
  assign bus.out_round = round_q;
  assign bus.out_err   = err_q;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      state_q <= '0;
      round_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      state_q <= bus.in_state ^ key;
      round_q <= bus.in_round;
      err_q   <= key_err;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_add_round_key.sv
// tb_add_round_key: directed plus random checks of a 128-bit and an 8-bit AddRoundKey instance
module tb_add_round_key;
  import add_round_key_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [127:0] mk [11];
  add_round_key_if #(.WIDTH(128), .IDX_W(4)) b128 ();
  add_round_key_if #(.WIDTH(8), .IDX_W(4)) b8 ();
  add_round_key #(.WIDTH(128), .NUM_KEYS(11)) d128 (.clk(clk), .rst_n(rst_n), .bus(b128));
  add_round_key #(.WIDTH(8), .NUM_KEYS(11)) d8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp_of(input logic [127:0] s, input round_idx_t r);
    return (r < 11) ? s ^ mk[r] : s;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wr_key(input round_idx_t idx, input logic [127:0] d);
    b128.key_wr_en = 1'b1;
    b128.key_wr_idx = idx;
    b128.key_wr_data = d;
    tick();
    b128.key_wr_en = 1'b0;
    if (idx < 11) mk[idx] = d;
  endtask

  task automatic send(input string tag, input logic [127:0] s, input round_idx_t r);
    logic [127:0] e;
    e = exp_of(s, r);
    b128.in_valid = 1'b1;
    b128.in_state = s;
    b128.in_round = r;
    b128.out_ready = 1'b1;
    tick();
    b128.in_valid = 1'b0;
    chk({tag, " valid"}, 128'(b128.out_valid), 128'd1);
    chk({tag, " state"}, b128.out_state, e);
    chk({tag, " round"}, 128'(b128.out_round), 128'(r));
    chk({tag, " err"}, 128'(b128.out_err), 128'(r >= 11));
  endtask

  initial begin
    logic [127:0] sa, sb, ea, eb, q_s[$];
    round_idx_t q_r[$];
    foreach (mk[i]) mk[i] = '0;
    {b128.key_wr_en, b128.key_wr_idx, b128.key_wr_data} = '0;
    {b128.in_valid, b128.in_state, b128.in_round, b128.out_ready} = '0;
    {b8.key_wr_en, b8.key_wr_idx, b8.key_wr_data} = '0;
    {b8.in_valid, b8.in_state, b8.in_round, b8.out_ready} = '0;
    tick();
    tick();
    chk("rst out_valid", 128'(b128.out_valid), 0);
    chk("rst out_state", b128.out_state, 0);
    chk("rst out_round", 128'(b128.out_round), 0);
    chk("rst out_err", 128'(b128.out_err), 0);
    chk("rst in_ready", 128'(b128.in_ready), 1);
    rst_n = 1'b1;
    send("zero keys", rnd128(), 4);
    wr_key(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    send("fips", 128'h3243f6a8885a308d313198a2e0370734, 0);
    chk("fips literal", b128.out_state, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
    // 8-bit instance
    b8.key_wr_en = 1'b1; b8.key_wr_idx = 3; b8.key_wr_data = 8'h9b;
    tick();
    b8.key_wr_en = 1'b0; b8.in_valid = 1'b1; b8.in_state = 8'hcb; b8.in_round = 3; b8.out_ready = 1'b1;
    tick();
    chk("w8 cb^9b", 128'(b8.out_state), 128'h50);
    b8.in_valid = 1'b0; b8.key_wr_en = 1'b1; b8.key_wr_data = 8'hff;
    tick();
    b8.key_wr_en = 1'b0; b8.in_valid = 1'b1; b8.in_state = 8'h00;
    tick();
    b8.in_valid = 1'b0;
    chk("w8 00^ff", 128'(b8.out_state), 128'hff);
    chk("w8 valid", 128'(b8.out_valid), 1);
    // random keys, then out-of-range writes must leave every entry unchanged
    for (int i = 0; i < 11; i++) wr_key(i[3:0], rnd128());
    for (int i = 11; i < 16; i++) wr_key(i[3:0], rnd128());
    for (int r = 0; r < 11; r++) send("keys intact", rnd128(), r[3:0]);
    // streaming rounds 0..10 back to back
    for (int r = 0; r < 11; r++) begin
      q_s.push_back(rnd128());
      q_r.push_back(r[3:0]);
    end
    b128.out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      b128.in_valid = 1'b1;
      b128.in_state = q_s[i];
      b128.in_round = q_r[i];
      tick();
      chk("stream valid", 128'(b128.out_valid), 1);
      chk("stream state", b128.out_state, exp_of(q_s[i], q_r[i]));
      chk("stream round", 128'(b128.out_round), 128'(q_r[i]));
    end
    b128.in_valid = 1'b0;
    tick();
    chk("drain valid", 128'(b128.out_valid), 0);
    // backpressure
    sa = rnd128();
    sb = rnd128();
    ea = exp_of(sa, 7);
    eb = exp_of(sb, 9);
    b128.out_ready = 1'b0;
    b128.in_valid = 1'b1; b128.in_state = sa; b128.in_round = 7;
    tick();
    b128.in_state = sb; b128.in_round = 9;
    for (int i = 0; i < 5; i++) begin
      chk("bp in_ready", 128'(b128.in_ready), 0);
      chk("bp hold state", b128.out_state, ea);
      chk("bp hold round", 128'(b128.out_round), 7);
      tick();
    end
    b128.out_ready = 1'b1;
    #1;
    chk("bp release ready", 128'(b128.in_ready), 1);
    tick();
    b128.in_valid = 1'b0;
    chk("bp second state", b128.out_state, eb);
    chk("bp second round", 128'(b128.out_round), 9);
    chk("bp second valid", 128'(b128.out_valid), 1);
    tick();
    chk("bp drained", 128'(b128.out_valid), 0);
    // same-edge key write and accept on entry 2
    wr_key(2, {16{8'h55}});
    ea = exp_of('0, 2);
    b128.key_wr_en = 1'b1; b128.key_wr_idx = 2; b128.key_wr_data = {16{8'haa}};
    b128.in_valid = 1'b1; b128.in_state = '0; b128.in_round = 2;
    tick();
    b128.key_wr_en = 1'b0;
    b128.in_valid = 1'b0;
    mk[2] = {16{8'haa}};
    chk("collide old key", b128.out_state, ea);
    chk("collide literal", b128.out_state, {16{8'h55}});
    send("collide new key", '0, 2);
    chk("collide new literal", b128.out_state, {16{8'haa}});
    // out-of-range rounds and random traffic
    sa = rnd128();
    send("round 12", sa, 12);
    chk("round 12 passthru", b128.out_state, sa);
    for (int i = 0; i < 20; i++) send("random", rnd128(), 4'($urandom_range(0, 15)));
    // reset while a result is held
    b128.out_ready = 1'b0;
    b128.in_valid = 1'b1; b128.in_state = rnd128(); b128.in_round = 1;
    tick();
    b128.in_valid = 1'b0;
    chk("pre-rst valid", 128'(b128.out_valid), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    foreach (mk[i]) mk[i] = '0;
    chk("mid rst valid", 128'(b128.out_valid), 0);
    chk("mid rst state", b128.out_state, 0);
    chk("mid rst err", 128'(b128.out_err), 0);
    for (int r = 0; r < 11; r++) begin
      send("post rst", {16{8'h5a}}, r[3:0]);
      chk("post rst literal", b128.out_state, {16{8'h5a}});
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
